// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit CPU front end.
package cpu_pkg;

  localparam int          DATA_W      = 16;
  localparam int          ADDR_W      = 16;
  localparam logic [15:0] RESET_PC    = 16'd10;
  localparam int          INSTR_BYTES = 2;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs; flush overrides push and pop.
module fetch_fifo #(
  parameter int WIDTH = cpu_pkg::DATA_W + cpu_pkg::ADDR_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  import cpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push != do_pop)
        count_q <= do_push ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, drives the req/ack instruction memory and
// delivers {instr, pc} from a prefetch FIFO; branch redirects flush it.
module instruction_fetch_unit #(
  parameter int                DATA_W     = cpu_pkg::DATA_W,
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(cpu_pkg::RESET_PC),
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e             state_q, state_d;
  logic                     mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;

  logic                     ack, push, pop, space_next;
  logic                     fifo_empty, fifo_full;
  logic [CNT_W-1:0]         count, count_next;
  logic [ADDR_W-1:0]        redirect_pc_al, next_seq_pc;
  logic [DATA_W+ADDR_W-1:0] head;
  logic                     unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[0];

  assign ack            = mem_req_q & mem_ack;
  // A redirect cancels both the pop and any push landing on the same edge.
  assign pop            = instr_valid & instr_ready & ~redirect;
  assign push           = ack & (state_q == FETCH) & ~redirect;
  assign redirect_pc_al = {redirect_pc[ADDR_W-1:1], 1'b0};
  assign next_seq_pc    = mem_addr_q + ADDR_W'(INSTR_BYTES);

  always_comb begin
    count_next = count;
    if (redirect)         count_next = '0;
    else if (push && !pop) count_next = count + CNT_W'(1);
    else if (!push && pop) count_next = count - CNT_W'(1);
  end

  assign space_next = (count_next < CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc_al;
          if (mem_req_q && !mem_ack) begin
            state_d = DISCARD;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = redirect_pc_al;
          end
        end else if (ack) begin
          fetch_pc_d = next_seq_pc;
          mem_req_d  = space_next;
          mem_addr_d = next_seq_pc;
        end else if (!mem_req_q && space_next) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      DISCARD: begin
        // The stale request must complete before the new stream starts.
        if (redirect) fetch_pc_d = redirect_pc_al;
        if (ack) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = redirect ? redirect_pc_al : fetch_pc_q;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .flush_i   (redirect),
    .wr_data_i ({mem_rdata, mem_addr_q}),
    .rd_data_o (head),
    .count_o   (count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    push |-> (!fifo_full || pop));

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = ~fifo_empty;
  assign instr       = head[ADDR_W +: DATA_W];
  assign instr_pc    = head[ADDR_W-1:0];

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream stage of the 16-bit CPU datapath. Owns the fetch PC and drives a variable-latency instruction memory through a req/ack handshake.
- Buffers fetched words in a small prefetch FIFO and presents {instruction, pc} to the datapath with valid/ready.
- Accepts branch redirects from the datapath (BEQ taken). A redirect flushes stale prefetched words.

Parameters:
- DATA_W, 16, instruction and memory data width
- ADDR_W, 16, byte address width
- RESET_PC, 16'd10, first fetch address after reset
- FIFO_DEPTH, 2, prefetch entries (power of two, >= 2)

Ports:
- Clock  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- mem_req  out  1  fetch request; held until mem_ack
- mem_addr  out  ADDR_W  fetch byte address; stable while mem_req=1
- mem_ack  in  1  memory accepted request and mem_rdata is valid this cycle; ignored when mem_req=0
- mem_rdata  in  DATA_W  fetched instruction word
- instr_valid  out  1  FIFO head holds a valid instruction
- instr_ready  in  1  datapath consumes head this cycle
- instr  out  DATA_W  head instruction word
- instr_pc  out  ADDR_W  byte address of head instruction
- redirect  in  1  taken branch; flush and restart
- redirect_pc  in  ADDR_W  new fetch address

Behaviour:
- Reset (async assert, sync release) sets:
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC
  - FIFO count=0, instr_valid=0, instr=0, instr_pc=0
  - state=FETCH
- All outputs are registered except instr_valid, instr and instr_pc, which are the FIFO head and empty flag.
- FSM states:
  - FETCH: normal operation.
  - DISCARD: a redirect arrived while a request was outstanding and unacked. mem_req stays 1 with the old mem_addr until mem_ack. The returned data is dropped. On ack, go to FETCH and issue a request at fetch_pc on the next cycle.
- Issue rule (FETCH): mem_req is set at the clock edge when it is not already set and (count_next + 0) < FIFO_DEPTH, with mem_addr=fetch_pc. count_next accounts for this cycle's pop.
  - First request is asserted the first cycle after Reset deasserts, with mem_addr=10.
- Ack in FETCH:
  - push {mem_rdata, mem_addr} into the FIFO
  - fetch_pc <= mem_addr+2, modulo 2^16 (0xFFFE wraps to 0x0000)
  - mem_req stays 1 with the new address in the following cycle if space remains after push/pop; otherwise it drops to 0
  - The issue rule guarantees a push never hits a full FIFO.
- Latency: ack at edge N gives instr_valid=1 from cycle N+1. A continuous zero-wait memory (ack same cycle as req) sustains 1 instruction/cycle when instr_ready=1.
- Pop: on instr_valid & instr_ready the head advances. Simultaneous push and pop keeps count unchanged.
- Redirect (highest priority), at the edge:
  - FIFO flushed; instr_valid=0 the next cycle
  - any pop in the same cycle is ignored (the consumed word is not re-delivered)
  - fetch_pc <= {redirect_pc[15:1], 1'b0}; odd addresses are force-aligned
  - if mem_req=1 and mem_ack=0: go to DISCARD
  - if mem_req=1 and mem_ack=1: the acked data is dropped, not pushed; mem_req=1 next cycle at the new PC
  - if mem_req=0: issue at the new PC next cycle
- Redirect while in DISCARD: update fetch_pc only and remain in DISCARD.
- Reset mid-transfer: drops mem_req immediately (async) and abandons the transaction. The memory model must tolerate this.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC
  - INSTR_BYTES=2
  - fetch-state enum {FETCH, DISCARD}
  - DATA_W/ADDR_W constants
- One natural sub-module: fetch_fifo. It is a synchronous FIFO of width DATA_W+ADDR_W with push, pop, flush, count, empty and full. Flush takes priority over push and pop.

Test Plan:
- Release Reset, zero-wait memory returning 0x1111, 0x2222, instr_ready=1 → mem_addr 10, 12, 14…; instr_valid from the cycle after the first ack; instr/instr_pc = 0x1111/10, then 0x2222/12 on consecutive cycles.
- instr_ready=0, memory acks every cycle → exactly 2 words buffered (pc 10, 12); mem_req drops to 0. Raise instr_ready → mem_req reasserts at 14 with no lost or duplicated words.
- 3-cycle ack latency, redirect to 0x0040 in the 2nd wait cycle → state DISCARD; mem_addr held at the old address until ack; that data never appears. Next request at 0x0040; first delivered instr_pc=0x0040.
- Redirect coincident with ack, redirect_pc=0x0031 → acked word dropped; next mem_addr=0x0030; FIFO empty the following cycle.
- Redirect to 0xFFFE, zero-wait → instr_pc sequence 0xFFFE, 0x0000, 0x0002.
- Assert Reset while mem_req=1 and FIFO holds 2 entries → same-cycle mem_req=0, instr_valid=0. After release, first fetch is at 10.
